// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the MEM stage.
// Data accesses win over fetches. A stuck bus is aborted after TIMEOUT_CYCLES and sets a sticky error flag.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        stallreq_if_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        stallreq_mem_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] DATA      = 3'd1;
    localparam logic [2:0] INST      = 3'd2;
    localparam logic [2:0] DATA_DONE = 3'd3;
    localparam logic [2:0] INST_DONE = 3'd4;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        err_q, err_d;
    logic        timeout;

    // An ack arriving on the last allowed wait cycle takes precedence over the abort.
    assign timeout = !bus_ack_i && (wait_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        req_d       = req_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (mem_ce_i) begin
                    addr_d  = mem_addr_i;
                    we_d    = mem_we_i;
                    sel_d   = mem_sel_i;
                    wdata_d = mem_wdata_i;
                    req_d   = 1'b1;
                    wait_d  = 8'd0;
                    state_d = DATA;
                end else if (if_ce_i) begin
                    addr_d  = if_addr_i;
                    we_d    = 1'b0;
                    sel_d   = 4'b1111;
                    req_d   = 1'b1;
                    wait_d  = 8'd0;
                    state_d = INST;
                end
            end
            DATA, INST: begin
                if (bus_ack_i || timeout) begin
                    req_d   = 1'b0;
                    state_d = (state_q == DATA) ? DATA_DONE : INST_DONE;
                    if (timeout) err_d = 1'b1;
                    if (!we_q) begin
                        if (state_q == DATA) mem_rdata_d = bus_ack_i ? bus_rdata_i : 32'h0;
                        else                 if_data_d   = bus_ack_i ? bus_rdata_i : 32'h0;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DATA_DONE, INST_DONE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= 8'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            req_q       <= req_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            err_q       <= err_d;
        end
    end

    assign stallreq_mem_o = mem_ce_i & (state_q != DATA_DONE);
    assign stallreq_if_o  = if_ce_i & (state_q != INST_DONE);
    assign bus_req_o      = req_q;
    assign bus_we_o       = we_q;
    assign bus_sel_o      = sel_q;
    assign bus_addr_o     = addr_q;
    assign bus_wdata_o    = wdata_q;
    assign if_data_o      = if_data_q;
    assign mem_rdata_o    = mem_rdata_q;
    assign bus_err_o      = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with TIMEOUT_CYCLES=4.
// Expected values are written out by hand for each step.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        stallreq_if_o;
    logic        mem_ce_i, mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        stallreq_mem_o;
    logic        bus_req_o, bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .stallreq_if_o(stallreq_if_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .stallreq_mem_o(stallreq_mem_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_store_fields(input string tag);
        chk({tag, "_req"},   32'(bus_req_o), 32'd1);
        chk({tag, "_we"},    32'(bus_we_o), 32'd1);
        chk({tag, "_sel"},   32'(bus_sel_o), 32'h3);
        chk({tag, "_addr"},  bus_addr_o, 32'h4000);
        chk({tag, "_wdata"}, bus_wdata_o, 32'hAAAA5555);
    endtask

    initial begin
        rst = 1'b1; if_ce_i = 1'b0; if_addr_i = 32'h0;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0;
        mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
        bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
        step(); step();
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_sel", 32'(bus_sel_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        chk("rst_ifdata", if_data_o, 32'd0);
        chk("rst_memdata", mem_rdata_o, 32'd0);
        rst = 1'b0;

        // zero-wait fetch
        if_ce_i = 1'b1; if_addr_i = 32'h100;
        #1;
        chk("f0_stall_idle", 32'(stallreq_if_o), 32'd1);
        step();
        chk("f0_req", 32'(bus_req_o), 32'd1);
        chk("f0_addr", bus_addr_o, 32'h100);
        chk("f0_sel", 32'(bus_sel_o), 32'hF);
        chk("f0_we", 32'(bus_we_o), 32'd0);
        chk("f0_stall_wait", 32'(stallreq_if_o), 32'd1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3C010001;
        step();
        chk("f0_done_req", 32'(bus_req_o), 32'd0);
        chk("f0_data", if_data_o, 32'h3C010001);
        chk("f0_done_stall", 32'(stallreq_if_o), 32'd0);
        bus_ack_i = 1'b0; if_ce_i = 1'b0;
        step();

        // simultaneous load + fetch: data first
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h2000;
        if_ce_i = 1'b1; if_addr_i = 32'h300;
        step();
        chk("sim_addr_data", bus_addr_o, 32'h2000);
        chk("sim_req", 32'(bus_req_o), 32'd1);
        chk("sim_if_stall", 32'(stallreq_if_o), 32'd1);
        chk("sim_mem_stall", 32'(stallreq_mem_o), 32'd1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
        step();
        chk("sim_memdata", mem_rdata_o, 32'h12345678);
        chk("sim_mem_stall_done", 32'(stallreq_mem_o), 32'd0);
        chk("sim_if_stall_done", 32'(stallreq_if_o), 32'd1);
        chk("sim_done_req", 32'(bus_req_o), 32'd0);
        mem_ce_i = 1'b0; bus_ack_i = 1'b0;
        step();
        chk("sim_idle_req", 32'(bus_req_o), 32'd0);
        chk("sim_idle_if_stall", 32'(stallreq_if_o), 32'd1);
        step();
        chk("sim_fetch_req", 32'(bus_req_o), 32'd1);
        chk("sim_fetch_addr", bus_addr_o, 32'h300);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
        step();
        chk("sim_ifdata", if_data_o, 32'hCAFEF00D);
        chk("sim_memdata_kept", mem_rdata_o, 32'h12345678);
        if_ce_i = 1'b0; bus_ack_i = 1'b0;
        step();

        // store, ack on 4th bus cycle (coincides with the timeout cycle: ack wins)
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
        mem_addr_i = 32'h4000; mem_wdata_i = 32'hAAAA5555;
        step();
        // MEM stage inputs change while the bus is busy; bus fields must not follow
        mem_addr_i = 32'hDEAD0000; mem_wdata_i = 32'h0; mem_sel_i = 4'hF;
        chk_store_fields("st_c0");
        step(); chk_store_fields("st_c1");
        step(); chk_store_fields("st_c2");
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0BADBAD0;
        #1;
        chk_store_fields("st_c3");
        step();
        chk("st_done_req", 32'(bus_req_o), 32'd0);
        chk("st_memdata_kept", mem_rdata_o, 32'h12345678);
        chk("st_err_ackwins", 32'(bus_err_o), 32'd0);
        chk("st_stall", 32'(stallreq_mem_o), 32'd0);
        mem_ce_i = 1'b0; mem_we_i = 1'b0; bus_ack_i = 1'b0;
        step();

        // ack while idle is ignored
        bus_ack_i = 1'b1; bus_rdata_i = 32'h77777777;
        step();
        chk("idle_ack_req", 32'(bus_req_o), 32'd0);
        chk("idle_ack_memdata", mem_rdata_o, 32'h12345678);
        chk("idle_ack_ifdata", if_data_o, 32'hCAFEF00D);
        bus_ack_i = 1'b0;

        // fetch flushed mid-transaction still completes
        if_ce_i = 1'b1; if_addr_i = 32'h700;
        step();
        if_ce_i = 1'b0;
        step();
        chk("fl_req_held", 32'(bus_req_o), 32'd1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000BEEF;
        step();
        chk("fl_ifdata", if_data_o, 32'h0000BEEF);
        chk("fl_req_low", 32'(bus_req_o), 32'd0);
        bus_ack_i = 1'b0;
        step();

        // load timeout
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h5000;
        step(); chk("to_req0", 32'(bus_req_o), 32'd1);
        step(); chk("to_req1", 32'(bus_req_o), 32'd1);
        step(); chk("to_req2", 32'(bus_req_o), 32'd1);
        step(); chk("to_req3", 32'(bus_req_o), 32'd1);
        chk("to_err_before", 32'(bus_err_o), 32'd0);
        chk("to_stall_wait", 32'(stallreq_mem_o), 32'd1);
        step();
        chk("to_req_low", 32'(bus_req_o), 32'd0);
        chk("to_err", 32'(bus_err_o), 32'd1);
        chk("to_memdata", mem_rdata_o, 32'h0);
        chk("to_stall_done", 32'(stallreq_mem_o), 32'd0);
        mem_ce_i = 1'b0;
        step();
        chk("to_err_sticky", 32'(bus_err_o), 32'd1);

        // reset during DATA wait cycle 2
        mem_ce_i = 1'b1; mem_addr_i = 32'h6000;
        step(); step(); step();
        chk("rm_req_before", 32'(bus_req_o), 32'd1);
        rst = 1'b1;
        step();
        chk("rm_req", 32'(bus_req_o), 32'd0);
        chk("rm_addr", bus_addr_o, 32'd0);
        chk("rm_err", 32'(bus_err_o), 32'd0);
        chk("rm_ifdata", if_data_o, 32'd0);
        chk("rm_stall", 32'(stallreq_mem_o), 32'd1);
        rst = 1'b0; mem_ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h55555555;
        step();
        chk("rm_late_ack_req", 32'(bus_req_o), 32'd0);
        chk("rm_late_ack_data", mem_rdata_o, 32'd0);
        bus_ack_i = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum cycles to wait for bus_ack_i before aborting; legal range 1..255.
REQ-002 SHALL have clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have rst  in  1  reset; one clock, synchronous, active-high (rst==1 resets on the clk edge).
REQ-004 SHALL have if_ce_i  in  1  instruction-fetch request.
REQ-005 SHALL have if_addr_i  in  32  fetch address.
REQ-006 SHALL have if_data_o  out  32  fetched instruction, registered.
REQ-007 SHALL have stallreq_if_o  out  1  fetch stall request to the pipeline controller.
REQ-008 SHALL have mem_ce_i, mem_we_i  in  1 each  data access enable and write enable from the MEM stage.
REQ-009 SHALL have mem_sel_i  in  4  byte lanes; mem_addr_i  in  32  data address; mem_wdata_i  in  32  store data.
REQ-010 SHALL have mem_rdata_o  out  32  load data returned to the MEM stage, registered.
REQ-011 SHALL have stallreq_mem_o  out  1  data-side stall request.
REQ-012 SHALL have bus_req_o, bus_we_o  out  1 each; bus_sel_o  out  4; bus_addr_o, bus_wdata_o  out  32  shared single-port bus, all registered.
REQ-013 SHALL have bus_rdata_i  in  32; bus_ack_i  in  1  one-cycle completion strobe.
REQ-014 SHALL have bus_err_o  out  1  sticky timeout flag.

Function
REQ-015 SHALL use the FSM states IDLE, DATA, INST, DATA_DONE and INST_DONE.
REQ-016 In IDLE with mem_ce_i=1, SHALL latch mem_addr_i, mem_we_i, mem_sel_i and mem_wdata_i onto the bus_* registers, set bus_req_o=1 and go to DATA; data has priority over fetch.
REQ-017 In IDLE with mem_ce_i=0 and if_ce_i=1, SHALL latch if_addr_i, bus_we_o=0 and bus_sel_o=4'b1111, set bus_req_o=1 and go to INST.
REQ-018 In DATA/INST with bus_ack_i=1, SHALL clear bus_req_o and go to DATA_DONE/INST_DONE.
REQ-019 On that ack edge, for a read, SHALL capture bus_rdata_i into mem_rdata_o (DATA) or if_data_o (INST); writes SHALL leave mem_rdata_o unchanged.
REQ-020 DATA_DONE and INST_DONE SHALL last exactly one cycle and then return to IDLE.
REQ-021 SHALL drive stallreq_mem_o = mem_ce_i & (state != DATA_DONE), combinationally.
REQ-022 SHALL drive stallreq_if_o = if_ce_i & (state != INST_DONE), combinationally.
REQ-023 Minimum latency with a zero-wait bus SHALL be: request seen in IDLE (cycle N), bus_req_o high in N+1, ack in N+1, DONE and stall low in N+2.
REQ-024 Back-to-back accesses SHALL pass through one IDLE cycle between DONE and the next bus_req_o.
REQ-025 A wait counter (8 bit) SHALL clear on entry to DATA/INST and increment each cycle without ack.
REQ-026 When the wait counter reaches TIMEOUT_CYCLES-1 without ack, SHALL clear bus_req_o, set bus_err_o=1, load 32'h0 into the active read-data register (reads only) and go to the matching DONE state.
REQ-027 bus_err_o SHALL stay set until rst.
REQ-028 bus_ack_i in IDLE or DONE SHALL be ignored.
REQ-029 An ack in the same cycle as the timeout SHALL win: normal completion, no error.
REQ-030 If the requester's ce drops mid-transaction (flush), SHALL still complete or time out the bus transaction normally; the result register updates and the DONE cycle still occurs.
REQ-031 bus_* outputs SHALL hold stable while bus_req_o=1.

Reset
REQ-032 rst=1 SHALL force, on the next edge, state=IDLE, counter=0, bus_req_o=0, bus_we_o=0, bus_sel_o=0, bus_addr_o=0, bus_wdata_o=0, if_data_o=0, mem_rdata_o=0 and bus_err_o=0, aborting any transaction in flight.
REQ-033 Stall outputs during reset SHALL follow REQ-021/REQ-022 with state=IDLE.

Verification
REQ-034 Fetch, zero-wait: if_ce_i=1, if_addr_i=0x100, ack with rdata=0x3C010001 in the first bus_req_o cycle -> if_data_o=0x3C010001 and stallreq_if_o low at N+2.
REQ-035 Simultaneous requests: mem_ce_i=1 load 0x2000 plus if_ce_i=1 -> DATA served first; fetch bus_req_o rises 1 cycle after DATA_DONE; stallreq_if_o stays high throughout the data access.
REQ-036 Store: mem_we_i=1, sel=4'b0011, wdata=0xAAAA5555, ack after 3 wait cycles -> bus fields stable for 4 cycles; mem_rdata_o unchanged.
REQ-037 Timeout: TIMEOUT_CYCLES=4, no ack -> bus_req_o high 4 cycles then low; bus_err_o=1; mem_rdata_o=0; stall low one cycle later.
REQ-038 Reset mid-transaction: rst in DATA wait cycle 2 -> next edge state IDLE, bus_req_o=0, all registers 0; a later ack is ignored.
